// File: rtl/pcie_pkg.sv
// Shared types and constants for the timing-model write-back path to PCIe memory.
// Each token is stored as a 4-word slot, and its header word is written last.
package pcie_pkg;

   localparam int unsigned NTHREADS             = 64;
   localparam int unsigned TIDW                 = $clog2(NTHREADS);
   localparam int unsigned PCIE_WORDS_PER_TOKEN = 4;
   localparam int unsigned PAYLOAD_W            = 96;
   localparam int unsigned WADDR_W              = 11;
   localparam int unsigned WDATA_W              = 32;
   localparam int unsigned HDR_TID_W            = 9;
   localparam int unsigned HDR_AB_BIT           = 31;
   localparam int unsigned HDR_TID_MSB          = 8;
   localparam int unsigned HDR_TID_LSB          = 0;

   typedef struct packed {
      logic [TIDW-1:0]      tid;
      logic [PAYLOAD_W-1:0] payload;
   } tm_wr_token_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W3,
      ST_W2,
      ST_W1,
      ST_W0
   } wr_state_e;

   // Body word k of the slot (k = 1..3); word 0 is the header.
   function automatic logic [WDATA_W-1:0] payload_word(input logic [PAYLOAD_W-1:0] payload,
                                                       input logic [1:0]           idx);
      case (idx)
         2'd1:    return payload[31:0];
         2'd2:    return payload[63:32];
         default: return payload[95:64];
      endcase
   endfunction

   function automatic logic [WDATA_W-1:0] hdr_word(input logic                 ab,
                                                   input logic [HDR_TID_W-1:0] tid);
      logic [WDATA_W-1:0] w;
      w                          = '0;
      w[HDR_AB_BIT]              = ab;
      w[HDR_TID_MSB:HDR_TID_LSB] = tid;
      return w;
   endfunction

   function automatic logic [WADDR_W-1:0] slot_addr(input logic [HDR_TID_W-1:0] tid,
                                                    input logic [1:0]           idx);
      return WADDR_W'({tid, idx});
   endfunction

endpackage

// File: rtl/pcie_tm_wrbuf_if.sv
// Bundle connecting the timing-model token input, the buffer status outputs, and the PCIe write port.
interface pcie_tm_wrbuf_if #(
   parameter int unsigned TIDW = pcie_pkg::TIDW,
   parameter int unsigned CNTW = 5
);
   logic            cpu2tm_valid;
   logic            cpu2tm_retired;
   logic [TIDW-1:0] cpu2tm_tid;
   logic [95:0]     cpu2tm_payload;
   logic            wb_nack;
   logic [CNTW-1:0] wb_count;
   logic            wb_idle;
   logic            pcie_we;
   logic [10:0]     pcie_waddr;
   logic [31:0]     pcie_wdata;
   logic            pcie_wr_busy;

   // The write buffer takes this side.
   modport slave (
      input  cpu2tm_valid, cpu2tm_retired, cpu2tm_tid, cpu2tm_payload, pcie_wr_busy,
      output wb_nack, wb_count, wb_idle, pcie_we, pcie_waddr, pcie_wdata
   );

   // The timing model and the memory together take this side.
   modport master (
      output cpu2tm_valid, cpu2tm_retired, cpu2tm_tid, cpu2tm_payload, pcie_wr_busy,
      input  wb_nack, wb_count, wb_idle, pcie_we, pcie_waddr, pcie_wdata
   );
endinterface

// File: rtl/tm_wr_fifo.sv
// Synchronous FIFO of write-back tokens that also reports its occupancy.
// Pushes while full and pops while empty are ignored.
module tm_wr_fifo
   import pcie_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNTW  = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  tm_wr_token_t    push_data,
   input  logic            pop,
   output tm_wr_token_t    head,
   output logic [CNTW-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);

   tm_wr_token_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign do_push = push && (count != CNTW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CNTW'(do_push) - CNTW'(do_pop);
      end
   end

   // The storage array has no reset, because the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/pcie_tm_wrbuf.sv
// Write-back buffer: captures retired tokens and serializes each one into a 4-word PCIe slot.
// The header word, which carries the A/B toggle, is written last.
module pcie_tm_wrbuf
   import pcie_pkg::*;
#(
   parameter int unsigned NTHREADS   = pcie_pkg::NTHREADS,
   parameter int unsigned TIDW       = $clog2(NTHREADS),
   parameter int unsigned FIFO_DEPTH = 16
) (
   input logic             clk,
   input logic             rst,
   pcie_tm_wrbuf_if.slave  bus
);

   localparam int unsigned CNTW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [1:0]  LAST_WORD = 2'(PCIE_WORDS_PER_TOKEN - 1);

   wr_state_e          state;
   tm_wr_token_t       hold;
   tm_wr_token_t       fifo_in;
   tm_wr_token_t       fifo_head;
   logic [CNTW-1:0]    fifo_count;
   logic [NTHREADS-1:0] ab_store;
   logic               we_q;
   logic [WADDR_W-1:0] waddr_q;
   logic [WDATA_W-1:0] wdata_q;

   logic cap_req;
   logic fifo_full;
   logic push;
   logic pop;
   logic wr_accept;

   // A full FIFO refuses a token even when a pop happens in the same cycle.
   assign cap_req   = bus.cpu2tm_valid && bus.cpu2tm_retired;
   assign fifo_full = (fifo_count == CNTW'(FIFO_DEPTH));
   assign push      = cap_req && !fifo_full;
   assign pop       = (state == ST_IDLE) && (fifo_count != '0);
   assign wr_accept = we_q && !bus.pcie_wr_busy;

   assign fifo_in.tid     = bus.cpu2tm_tid;
   assign fifo_in.payload = bus.cpu2tm_payload;

   tm_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNTW  (CNTW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (fifo_in),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   // Burst sequencer. While the memory is busy, the registered outputs are simply held.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         hold     <= '0;
         ab_store <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  hold    <= fifo_head;
                  state   <= ST_W3;
                  we_q    <= 1'b1;
                  waddr_q <= slot_addr(HDR_TID_W'(fifo_head.tid), LAST_WORD);
                  wdata_q <= payload_word(fifo_head.payload, LAST_WORD);
               end
            end
            ST_W3: begin
               if (wr_accept) begin
                  state   <= ST_W2;
                  waddr_q <= slot_addr(HDR_TID_W'(hold.tid), 2'd2);
                  wdata_q <= payload_word(hold.payload, 2'd2);
               end
            end
            ST_W2: begin
               if (wr_accept) begin
                  state   <= ST_W1;
                  waddr_q <= slot_addr(HDR_TID_W'(hold.tid), 2'd1);
                  wdata_q <= payload_word(hold.payload, 2'd1);
               end
            end
            ST_W1: begin
               if (wr_accept) begin
                  state   <= ST_W0;
                  waddr_q <= slot_addr(HDR_TID_W'(hold.tid), 2'd0);
                  wdata_q <= hdr_word(~ab_store[hold.tid], HDR_TID_W'(hold.tid));
               end
            end
            ST_W0: begin
               if (wr_accept) begin
                  state              <= ST_IDLE;
                  we_q               <= 1'b0;
                  ab_store[hold.tid] <= ~ab_store[hold.tid];
               end
            end
            default: begin
               state <= ST_IDLE;
               we_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pcie_we    = we_q;
   assign bus.pcie_waddr = waddr_q;
   assign bus.pcie_wdata = wdata_q;
   assign bus.wb_count   = fifo_count;
   assign bus.wb_idle    = (fifo_count == '0) && (state == ST_IDLE);
   assign bus.wb_nack    = cap_req && fifo_full;

endmodule
